mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide unit for the Execute stage.
// One iteration per cycle: shift-add for MUL/MULH/MULHSU/MULHU and restoring
// division for DIV/DIVU/REM/REMU. Signed ops work on magnitudes and the sign
// is applied when the final value is captured into the result register.
//
// Build option: define MDU_DIV_EN to include the divider. Without it, divide
// ops (op_E[2]=1) complete in one cycle with result 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start_E      Execute stage holds a valid RV32M op
//   op_E         RV32M funct3
//   src_a_E      forwarded operand A
//   src_b_E      forwarded operand B
//   flush_E      Execute-stage flush
//   stall_E      holds the IF/ID/EX pipeline registers
//   busy         sequencer is not idle
//   result_valid one-cycle strobe, result is valid
//   result       MDU result, held until the next completion
module mdu_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_E,
  input  logic [2:0]      op_E,
  input  logic [XLEN-1:0] src_a_E,
  input  logic [XLEN-1:0] src_b_E,
  input  logic            flush_E,
  output logic            stall_E,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  hi_q, lo_q, addend_q, result_q;
`ifdef MDU_DIV_EN
  logic             div_q;
  logic             div_zero, div_ovf;
  logic [XLEN:0]    r_sh;
  logic             ge;
  logic [XLEN-1:0]  diff, dval;
`endif

  logic             accept, fast, last;
  logic             sign_a, sign_b, neg_in;
  logic [XLEN-1:0]  mag_a, mag_b, fast_res;
  logic [XLEN:0]    sum;
  logic [XLEN-1:0]  hi_nxt, lo_nxt, mul_res, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  assign accept = (state == IDLE) & start_E & ~flush_E;
  assign last   = (cnt == CNT_W'(XLEN-1));

  // Operand decode: magnitudes, result sign and the single-cycle cases.
  always_comb begin
    sign_a = src_a_E[XLEN-1] & ((op_E == 3'b001) | (op_E == 3'b010) |
                                (op_E == 3'b100) | (op_E == 3'b110));
    sign_b = src_b_E[XLEN-1] & ((op_E == 3'b001) | (op_E == 3'b100) |
                                (op_E == 3'b110));
    mag_a  = sign_a ? -src_a_E : src_a_E;
    mag_b  = sign_b ? -src_b_E : src_b_E;
    // Remainder takes the dividend's sign; everything else the XOR.
    neg_in = (op_E == 3'b110) ? sign_a : (sign_a ^ sign_b);
`ifdef MDU_DIV_EN
    div_zero = op_E[2] & (src_b_E == '0);
    div_ovf  = op_E[2] & ~op_E[0] & (src_a_E == {1'b1, {(XLEN-1){1'b0}}}) &
               (src_b_E == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = op_E[1] ? src_a_E : '1;
    else          fast_res = op_E[1] ? '0 : src_a_E;
`else
    fast     = op_E[2];
    fast_res = '0;
`endif
  end

  // One iteration of the shared hi/lo datapath.
  always_comb begin
    sum              = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
    {hi_nxt, lo_nxt} = {sum, lo_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
    r_sh = {hi_q, lo_q[XLEN-1]};
    ge   = (r_sh >= {1'b0, addend_q});
    diff = r_sh[XLEN-1:0] - addend_q;
    if (div_q) begin
      hi_nxt = ge ? diff : r_sh[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], ge};
    end
`endif
  end

  // Final value after the last iteration, with sign applied.
  always_comb begin
    prod      = {hi_nxt, lo_nxt};
    prod_s    = neg_q ? -prod : prod;
    mul_res   = (op_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    final_res = mul_res;
`ifdef MDU_DIV_EN
    dval = op_q[1] ? hi_nxt : lo_nxt;
    if (div_q) final_res = neg_q ? -dval : dval;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = fast ? DONE : RUN;
      RUN: begin
        if (flush_E)   state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_E      = rst & ~flush_E & (((state == IDLE) & start_E) | (state == RUN));
    busy         = (state != IDLE);
    result_valid = (state == DONE) & ~flush_E;
    result       = result_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      addend_q <= '0;
      result_q <= '0;
`ifdef MDU_DIV_EN
      div_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q     <= op_E[1:0];
        neg_q    <= neg_in;
        hi_q     <= '0;
        // Multiply: lo holds the multiplier. Divide: lo holds the dividend.
        lo_q     <= op_E[2] ? mag_a : mag_b;
        addend_q <= op_E[2] ? mag_b : mag_a;
        cnt      <= '0;
`ifdef MDU_DIV_EN
        div_q    <= op_E[2];
`endif
        if (fast) result_q <= fast_res;
      end else if ((state == RUN) && !flush_E) begin
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
        cnt  <= cnt + CNT_W'(1);
        if (last) result_q <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_E, flush_E;
  logic [2:0]  op_E;
  logic [31:0] src_a_E, src_b_E;
  logic        stall_E, busy, result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_E(start_E), .op_E(op_E),
    .src_a_E(src_a_E), .src_b_E(src_b_E), .flush_E(flush_E),
    .stall_E(stall_E), .busy(busy), .result_valid(result_valid),
    .result(result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M op: {single_cycle, value}.
  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          qa, qb;
    logic [32:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = {1'b0, p[31:0]};  end
      3'd1: begin p = sa * sb; r = {1'b0, p[63:32]}; end
      3'd2: begin p = sa * ub; r = {1'b0, p[63:32]}; end
      3'd3: begin p = ua * ub; r = {1'b0, p[63:32]}; end
      default: begin
`ifdef MDU_DIV_EN
        qa = $signed(a);
        qb = $signed(b);
        if (b == 32'h0)
          r = {1'b1, op[1] ? a : 32'hFFFFFFFF};
        else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
          r = {1'b1, op[1] ? 32'h0 : 32'h80000000};
        else case (op)
          3'd4:    r = {1'b0, 32'(qa / qb)};
          3'd5:    r = {1'b0, a / b};
          3'd6:    r = {1'b0, 32'(qa % qb)};
          default: r = {1'b0, a % b};
        endcase
`else
        qa = 0; qb = 0;
        r = {1'b1, 32'h0};
`endif
      end
    endcase
    return r;
  endfunction

  // Reference model: cycles left before completion, plus a done flag.
  int          m_wait    = 0;
  bit          m_done    = 1'b0;
  logic [31:0] m_result  = '0;
  logic [31:0] m_pending = '0;
  logic [32:0] ref_now;

  always_comb ref_now = ref_op(op_E, src_a_E, src_b_E);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wait   <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_wait > 0) begin
      if (flush_E) m_wait <= 0;
      else begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_done   <= 1'b1;
          m_result <= m_pending;
        end
      end
    end else if (start_E && !flush_E) begin
      if (ref_now[32]) begin
        m_done   <= 1'b1;
        m_result <= ref_now[31:0];
      end else begin
        m_wait    <= 32;
        m_pending <= ref_now[31:0];
      end
    end
  end

  always @(negedge clk) begin
    check("stall_E", {31'b0, stall_E},
          {31'b0, rst && !flush_E && ((m_wait == 0 && !m_done && start_E) || m_wait > 0)});
    check("busy", {31'b0, busy}, {31'b0, (m_wait > 0) || m_done});
    check("result_valid", {31'b0, result_valid}, {31'b0, m_done && !flush_E});
    check("result", result, m_result);
  end

  // Issue one op at the current cycle; returns completion cycle (or -1),
  // the cycle busy dropped without a result (or -1), stalled cycles, result.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input bit hold,
                       output int lat, output int ex, output int stalls,
                       output logic [31:0] res);
    lat = -1; ex = -1; stalls = 0; res = '0;
    start_E = 1'b1; op_E = op; src_a_E = a; src_b_E = b;
    flush_E = (flush_at == 0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (stall_E) stalls++;
      if (result_valid) begin lat = c; res = result; break; end
      if (c > 0 && !busy) begin ex = c; break; end
      @(posedge clk); #2;
      start_E = hold;
      flush_E = (c + 1 == flush_at);
    end
    @(posedge clk); #2;
    start_E = 1'b0;
    flush_E = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, ex, st, fl, gap;
    logic [31:0] res, a, b;
    logic [2:0]  op;
    logic [32:0] r;
    bit hold;

    rst = 1'b1; start_E = 1'b1; flush_E = 1'b0; op_E = 3'd0;
    src_a_E = 32'd5; src_b_E = 32'd7;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'b0, stall_E}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_rv", {31'b0, result_valid}, 32'h0);
    check("reset_result", result, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;

    do_op(3'd0, 32'd7, 32'd6, -1, 1'b0, lat, ex, st, res);
    check("mul_lat", 32'(lat), 32'd33);
    check("mul_stalls", 32'(st), 32'd33);
    check("mul_res", res, 32'd42);

    do_op(3'd1, 32'h80000000, 32'h80000000, -1, 1'b0, lat, ex, st, res);
    check("mulh_res", res, 32'h40000000);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, lat, ex, st, res);
    check("mulhu_res", res, 32'hFFFFFFFE);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, -1, 1'b0, lat, ex, st, res);
    check("mulhsu_res", res, 32'hFFFFFFFF);

`ifdef MDU_DIV_EN
    do_op(3'd4, -32'd7, 32'd2, -1, 1'b0, lat, ex, st, res);
    check("div_res", res, 32'hFFFFFFFD);
    check("div_lat", 32'(lat), 32'd33);
    do_op(3'd6, -32'd7, 32'd2, -1, 1'b0, lat, ex, st, res);
    check("rem_res", res, 32'hFFFFFFFF);
    do_op(3'd5, 32'd10, 32'd0, -1, 1'b0, lat, ex, st, res);
    check("divu_zero_res", res, 32'hFFFFFFFF);
    check("divu_zero_stalls", 32'(st), 32'd1);
    check("divu_zero_lat", 32'(lat), 32'd1);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0, lat, ex, st, res);
    check("div_ovf_res", res, 32'h80000000);
    check("div_ovf_lat", 32'(lat), 32'd1);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0, lat, ex, st, res);
    check("rem_ovf_res", res, 32'h0);
    do_op(3'd7, 32'h1234, 32'd0, -1, 1'b0, lat, ex, st, res);
    check("remu_zero_res", res, 32'h1234);
`else
    do_op(3'd5, 32'd10, 32'd3, -1, 1'b0, lat, ex, st, res);
    check("divu_nodiv_res", res, 32'h0);
    check("divu_nodiv_lat", 32'(lat), 32'd1);
    check("divu_nodiv_stalls", 32'(st), 32'd1);
`endif

    // Flush at iteration 10 (cycle 11).
    do_op(3'd0, 32'd1000, 32'd3000, 11, 1'b0, lat, ex, st, res);
    check("flush_no_result", 32'(lat), 32'hFFFFFFFF);
    check("flush_exit_cycle", 32'(ex), 32'd12);
    check("flush_stalls", 32'(st), 32'd11);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, lat, ex, st, res);
    check("after_flush_res", res, 32'hFFFFFFFE);
    check("after_flush_lat", 32'(lat), 32'd33);

    // Reset during iteration 20 (cycle 21).
    start_E = 1'b1; op_E = 3'd0; src_a_E = 32'd123; src_b_E = 32'd456;
    @(posedge clk); #2;
    start_E = 1'b0;
    repeat (20) begin @(posedge clk); #2; end
    start_E = 1'b1; src_a_E = 32'd9; src_b_E = 32'd5;
    rst = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall_E}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_rv", {31'b0, result_valid}, 32'h0);
    check("midrst_result", result, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    do_op(3'd0, 32'd9, 32'd5, -1, 1'b0, lat, ex, st, res);
    check("post_rst_lat", 32'(lat), 32'd33);
    check("post_rst_res", res, 32'd45);

    for (int i = 0; i < 80; i++) begin
      op   = 3'($urandom_range(0, 7));
      a    = pick();
      b    = pick();
      fl   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 34)) : -1;
      hold = (fl < 0) && ($urandom_range(0, 3) == 0);
      do_op(op, a, b, fl, hold, lat, ex, st, res);
      if (fl < 0) begin
        r = ref_op(op, a, b);
        check("rand_res", res, r[31:0]);
        check("rand_lat", 32'(lat), r[32] ? 32'd1 : 32'd33);
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin @(posedge clk); #2; end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
